// File: rtl/riscv_bif_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_bif_arb_pkg
// Description : Shared grant-state encodings and read-source tag values for
//               the bus-interface arbiter and its tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_bif_arb_pkg;

  // Grant FSM states
  typedef enum logic [1:0] {
    BIF_IDLE  = 2'd0,
    BIF_OWN_I = 2'd1,
    BIF_OWN_D = 2'd2
  } bif_state_e;

  // Source tags for outstanding reads
  localparam logic BIF_SRC_I = 1'b0;
  localparam logic BIF_SRC_D = 1'b1;

endpackage : riscv_bif_arb_pkg
`default_nettype wire

// File: rtl/riscv_bif_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : riscv_bif_tag_fifo
// Description : In-order 1-bit tag FIFO recording which master issued each
//               outstanding read. Registered count; push when full and pop
//               when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_bif_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic pop_tag,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_cnt == CNT_W'(DEPTH));
  assign empty   = (r_cnt == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign pop_tag = r_mem[r_rptr];

  // Circular storage, pointers wrap at DEPTH; simultaneous push/pop keeps count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_tag;
        r_wptr        <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule : riscv_bif_tag_fifo
`default_nettype wire

// File: rtl/riscv_bif_arb.sv
`default_nettype none
// ============================================================================
// Module      : riscv_bif_arb
// Description : Arbitrates the fetch and data buses onto one memory port.
//               Data has priority, a starvation counter guarantees fetch
//               progress, and a tag FIFO routes in-order read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_bif_arb
  import riscv_bif_arb_pkg::*;
#(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_bif_req,
  input  logic [31:0] inst_bif_addr,
  output logic        inst_bif_ack,
  output logic        inst_bif_rvalid,
  output logic [31:0] inst_bif_rdata,
  input  logic        data_bif_req,
  input  logic [31:0] data_bif_addr,
  input  logic        data_bif_rnw,
  input  logic [3:0]  data_bif_wmask,
  input  logic [31:0] data_bif_wdata,
  output logic        data_bif_ack,
  output logic        data_bif_rvalid,
  output logic [31:0] data_bif_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_rnw,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bif_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  bif_state_e       r_state;
  logic [SW-1:0]    r_starve;
  logic             r_err;
  logic             w_sel_i;
  logic             w_sel_d;
  logic             w_starved;
  logic             w_sel_req;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_head;
  logic             w_pop;

  assign w_starved = (r_starve == SW'(STARVE_LIMIT));

  // Select the master driving the port: locked owner, else priority choice
  always_comb begin
    w_sel_i = 1'b0;
    w_sel_d = 1'b0;
    if (rstn) begin
      case (r_state)
        BIF_OWN_I: w_sel_i = 1'b1;
        BIF_OWN_D: w_sel_d = 1'b1;
        default: begin
          if (inst_bif_req && w_starved)  w_sel_i = 1'b1;
          else if (data_bif_req)          w_sel_d = 1'b1;
          else if (inst_bif_req)          w_sel_i = 1'b1;
        end
      endcase
    end
  end

  // Request mux; reads stall on a full tag FIFO, writes never do
  assign mem_rnw   = w_sel_i | (w_sel_d & data_bif_rnw);
  assign w_sel_req = (w_sel_i & inst_bif_req) | (w_sel_d & data_bif_req);
  assign mem_req   = w_sel_req & ~(w_full & mem_rnw);
  assign mem_addr  = w_sel_i ? inst_bif_addr : (w_sel_d ? data_bif_addr : 32'h0);
  assign mem_wmask = w_sel_d ? data_bif_wmask : 4'h0;
  assign mem_wdata = w_sel_d ? data_bif_wdata : 32'h0;

  assign w_accept     = mem_req & mem_ack;
  assign inst_bif_ack = w_accept & w_sel_i;
  assign data_bif_ack = w_accept & w_sel_d;

  // Response demux driven by the oldest outstanding tag
  assign w_pop           = rstn & mem_rvalid & ~w_empty;
  assign inst_bif_rvalid = w_pop & (w_head == BIF_SRC_I);
  assign data_bif_rvalid = w_pop & (w_head == BIF_SRC_D);
  assign inst_bif_rdata  = rstn ? mem_rdata : 32'h0;
  assign data_bif_rdata  = rstn ? mem_rdata : 32'h0;
  assign bif_err         = r_err;

  riscv_bif_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (w_accept & mem_rnw),
    .push_tag (w_sel_d ? BIF_SRC_D : BIF_SRC_I),
    .pop      (w_pop),
    .pop_tag  (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Grant FSM: lock the port on an unaccepted request, release on accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= BIF_IDLE;
    end else begin
      case (r_state)
        BIF_IDLE: begin
          if (mem_req && !mem_ack) r_state <= w_sel_d ? BIF_OWN_D : BIF_OWN_I;
        end
        BIF_OWN_I, BIF_OWN_D: begin
          if (w_accept) r_state <= BIF_IDLE;
        end
        default: r_state <= BIF_IDLE;
      endcase
    end
  end

  // Starvation counter: counts cycles fetch waits, saturating at the limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve <= '0;
    end else if (!inst_bif_req || inst_bif_ack) begin
      r_starve <= '0;
    end else if (!w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Sticky error: a response arrived with nothing outstanding
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (mem_rvalid && w_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule : riscv_bif_arb
`default_nettype wire

// File: tb/tb_riscv_bif_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_bif_arb
// Description : Self-checking bench for riscv_bif_arb: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_bif_arb;

  localparam int MAXO   = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_bif_req;
  logic [31:0] inst_bif_addr;
  logic        data_bif_req;
  logic [31:0] data_bif_addr;
  logic        data_bif_rnw;
  logic [3:0]  data_bif_wmask;
  logic [31:0] data_bif_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  wire         inst_bif_ack, inst_bif_rvalid, data_bif_ack, data_bif_rvalid;
  wire  [31:0] inst_bif_rdata, data_bif_rdata, mem_addr, mem_wdata;
  wire         mem_req, mem_rnw, bif_err;
  wire  [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  riscv_bif_arb #(.MAX_OUTST(MAXO), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rstn(rstn),
    .inst_bif_req(inst_bif_req), .inst_bif_addr(inst_bif_addr),
    .inst_bif_ack(inst_bif_ack), .inst_bif_rvalid(inst_bif_rvalid),
    .inst_bif_rdata(inst_bif_rdata),
    .data_bif_req(data_bif_req), .data_bif_addr(data_bif_addr),
    .data_bif_rnw(data_bif_rnw), .data_bif_wmask(data_bif_wmask),
    .data_bif_wdata(data_bif_wdata), .data_bif_ack(data_bif_ack),
    .data_bif_rvalid(data_bif_rvalid), .data_bif_rdata(data_bif_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bif_err(bif_err)
  );

  always #5 clk = ~clk;

  // ---------------- transaction-level reference model ----------------
  // m_owner: 0 = port free, 1 = fetch holds it, 2 = data holds it
  int  m_owner;
  bit  m_q[$];        // issuers of outstanding reads, oldest first (1 = data)
  int  m_wait;        // consecutive cycles fetch has been waiting
  bit  m_err;
  int  e_who;
  bit  e_req, e_rnw, e_iack, e_dack, e_irv, e_drv;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wmask;

  function automatic void model_reset();
    m_owner = 0; m_q.delete(); m_wait = 0; m_err = 0;
  endfunction

  function automatic void model_eval();
    bit has;
    if (!rstn)                                 e_who = 0;
    else if (m_owner != 0)                     e_who = m_owner;
    else if (inst_bif_req && m_wait >= STARVE) e_who = 1;
    else if (data_bif_req)                     e_who = 2;
    else if (inst_bif_req)                     e_who = 1;
    else                                       e_who = 0;
    has     = (e_who == 1) ? inst_bif_req : (e_who == 2) ? data_bif_req : 1'b0;
    e_rnw   = (e_who == 1) || (e_who == 2 && data_bif_rnw);
    e_req   = has && !(e_rnw && m_q.size() == MAXO);
    e_addr  = (e_who == 1) ? inst_bif_addr : (e_who == 2) ? data_bif_addr : 32'h0;
    e_wdata = (e_who == 2) ? data_bif_wdata : 32'h0;
    e_wmask = (e_who == 2) ? data_bif_wmask : 4'h0;
    e_iack  = mem_ack && e_req && e_who == 1;
    e_dack  = mem_ack && e_req && e_who == 2;
    e_irv   = rstn && mem_rvalid && m_q.size() > 0 && m_q[0] == 1'b0;
    e_drv   = rstn && mem_rvalid && m_q.size() > 0 && m_q[0] == 1'b1;
    e_rdata = rstn ? mem_rdata : 32'h0;
  endfunction

  function automatic void model_update();
    if (mem_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (mem_ack && e_req && e_rnw) m_q.push_back(e_who == 2);
    if (mem_ack && e_req) m_owner = 0;
    else if (m_owner == 0 && e_req) m_owner = e_who;
    if (!inst_bif_req || e_iack) m_wait = 0;
    else if (m_wait < STARVE) m_wait++;
  endfunction

  task automatic cyc_wait();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_update();
    #1;
  endtask

  task automatic idle_inputs();
    inst_bif_req = 0; inst_bif_addr = 0;
    data_bif_req = 0; data_bif_addr = 0; data_bif_rnw = 0;
    data_bif_wmask = 0; data_bif_wdata = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    inst_bif_req = 1; data_bif_req = 1; inst_bif_addr = 32'h44;
    #2;
    total++;
    if ({mem_req, mem_rnw, mem_wmask, inst_bif_ack, data_bif_ack, inst_bif_rvalid,
         data_bif_rvalid, bif_err} !== 10'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
        || inst_bif_rdata !== 32'h0 || data_bif_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b addr=%h err=%b want all zero", mem_req, mem_addr, bif_err);
    end
    idle_inputs();
    @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic test_contention();
    inst_bif_req = 1; inst_bif_addr = 32'h200;
    data_bif_req = 1; data_bif_addr = 32'h100; data_bif_rnw = 1; mem_ack = 1;
    cyc_wait();
    total++;
    if (data_bif_ack !== 1'b1 || inst_bif_ack !== 1'b0 || mem_addr !== 32'h100 || mem_rnw !== 1'b1) begin
      bad++;
      $display("FAIL contention_data_first: got dack=%b iack=%b addr=%h want 1 0 00000100", data_bif_ack, inst_bif_ack, mem_addr);
    end
    tick();
    data_bif_req = 0;
    cyc_wait();
    total++;
    if (inst_bif_ack !== 1'b1 || mem_addr !== 32'h200) begin
      bad++;
      $display("FAIL contention_fetch_next: got iack=%b addr=%h want 1 00000200", inst_bif_ack, mem_addr);
    end
    tick();
    inst_bif_req = 0; mem_ack = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA;
    cyc_wait();
    total++;
    if (data_bif_rvalid !== 1'b1 || inst_bif_rvalid !== 1'b0 || data_bif_rdata !== 32'hAAAA) begin
      bad++;
      $display("FAIL contention_resp_data: got drv=%b irv=%b rdata=%h want 1 0 0000aaaa", data_bif_rvalid, inst_bif_rvalid, data_bif_rdata);
    end
    tick();
    mem_rdata = 32'hBBBB;
    cyc_wait();
    total++;
    if (inst_bif_rvalid !== 1'b1 || data_bif_rvalid !== 1'b0 || inst_bif_rdata !== 32'hBBBB) begin
      bad++;
      $display("FAIL contention_resp_inst: got irv=%b drv=%b rdata=%h want 1 0 0000bbbb", inst_bif_rvalid, data_bif_rvalid, inst_bif_rdata);
    end
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_starvation();
    data_bif_req = 1; data_bif_rnw = 0; data_bif_addr = 32'h40;
    data_bif_wmask = 4'hF; data_bif_wdata = 32'h5555_AAAA;
    inst_bif_req = 1; mem_ack = 1;
    for (int round = 0; round < 2; round++) begin
      int n = 0;
      bit found = 0;
      inst_bif_addr = 32'h500 + 32'(round * 4);
      for (int c = 0; c < 10 && !found; c++) begin
        cyc_wait();
        n = c + 1;
        if (inst_bif_ack === 1'b1) found = 1;
        tick();
      end
      // four data wins (wait count 0..3), fetch forced on the fifth cycle
      total++;
      if (!found || n != 5) begin
        bad++;
        $display("FAIL starvation_round%0d: got found=%b cycles=%0d want 1 5", round, found, n);
      end
    end
    inst_bif_req = 0; data_bif_req = 0; mem_ack = 0; mem_rvalid = 1;
    for (int k = 0; k < 2; k++) begin
      mem_rdata = 32'h1000 + 32'(k);
      cyc_wait();
      total++;
      if (inst_bif_rvalid !== 1'b1 || data_bif_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL starvation_drain%0d: got irv=%b drv=%b want 1 0", k, inst_bif_rvalid, data_bif_rvalid);
      end
      tick();
    end
    mem_rvalid = 0;
  endtask

  task automatic test_lock();
    inst_bif_req = 1; inst_bif_addr = 32'h300; mem_ack = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        data_bif_req = 1; data_bif_addr = 32'h400; data_bif_rnw = 1; data_bif_wmask = 0;
      end
      cyc_wait();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || inst_bif_ack !== 1'b0 || data_bif_ack !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold%0d: got req=%b addr=%h want 1 00000300", c, mem_req, mem_addr);
      end
      tick();
    end
    mem_ack = 1;
    cyc_wait();
    total++;
    if (inst_bif_ack !== 1'b1 || data_bif_ack !== 1'b0 || mem_addr !== 32'h300) begin
      bad++;
      $display("FAIL lock_release: got iack=%b dack=%b addr=%h want 1 0 00000300", inst_bif_ack, data_bif_ack, mem_addr);
    end
    tick();
    inst_bif_req = 0;
    cyc_wait();
    total++;
    if (data_bif_ack !== 1'b1 || mem_addr !== 32'h400) begin
      bad++;
      $display("FAIL lock_data_after: got dack=%b addr=%h want 1 00000400", data_bif_ack, mem_addr);
    end
    tick();
    data_bif_req = 0; mem_ack = 0; mem_rvalid = 1;
    for (int k = 0; k < 2; k++) begin
      mem_rdata = 32'h2000 + 32'(k);
      cyc_wait();
      total++;
      if (inst_bif_rvalid !== (k == 0) || data_bif_rvalid !== (k == 1)) begin
        bad++;
        $display("FAIL lock_drain%0d: got irv=%b drv=%b want %b %b", k, inst_bif_rvalid, data_bif_rvalid, k == 0, k == 1);
      end
      tick();
    end
    mem_rvalid = 0;
  endtask

  task automatic test_full();
    data_bif_req = 1; data_bif_rnw = 1; data_bif_wmask = 0; mem_ack = 1;
    for (int k = 0; k < 2; k++) begin
      data_bif_addr = 32'h10 + 32'(4 * k);
      cyc_wait();
      total++;
      if (data_bif_ack !== 1'b1) begin
        bad++;
        $display("FAIL full_fill%0d: got dack=%b want 1", k, data_bif_ack);
      end
      tick();
    end
    data_bif_addr = 32'h18;
    cyc_wait();
    total++;
    if (mem_req !== 1'b0 || data_bif_ack !== 1'b0) begin
      bad++;
      $display("FAIL full_block: got req=%b dack=%b want 0 0", mem_req, data_bif_ack);
    end
    tick();
    data_bif_req = 0;
    cyc_wait(); tick();
    data_bif_req = 1; data_bif_rnw = 0; data_bif_addr = 32'h20;
    data_bif_wdata = 32'h1234_5678; data_bif_wmask = 4'h3;
    cyc_wait();
    total++;
    if (mem_req !== 1'b1 || data_bif_ack !== 1'b1 || mem_rnw !== 1'b0 ||
        mem_wdata !== 32'h1234_5678 || mem_wmask !== 4'h3) begin
      bad++;
      $display("FAIL full_write_pass: got req=%b dack=%b wdata=%h wmask=%h want 1 1 12345678 3", mem_req, data_bif_ack, mem_wdata, mem_wmask);
    end
    tick();
    data_bif_rnw = 1; data_bif_addr = 32'h18; data_bif_wmask = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    cyc_wait();
    total++;
    if (mem_req !== 1'b0 || data_bif_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_same_cycle: got req=%b drv=%b want 0 1", mem_req, data_bif_rvalid);
    end
    tick();
    mem_rvalid = 0;
    cyc_wait();
    total++;
    if (mem_req !== 1'b1 || data_bif_ack !== 1'b1 || mem_addr !== 32'h18) begin
      bad++;
      $display("FAIL full_unblock: got req=%b dack=%b addr=%h want 1 1 00000018", mem_req, data_bif_ack, mem_addr);
    end
    tick();
    data_bif_req = 0; mem_ack = 0; mem_rvalid = 1;
    for (int k = 0; k < 2; k++) begin
      cyc_wait();
      total++;
      if (data_bif_rvalid !== 1'b1 || inst_bif_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL full_drain%0d: got drv=%b irv=%b want 1 0", k, data_bif_rvalid, inst_bif_rvalid);
      end
      tick();
    end
    mem_rvalid = 0;
  endtask

  task automatic test_error();
    mem_rvalid = 1; mem_rdata = 32'hDEAD;
    cyc_wait();
    total++;
    if (inst_bif_rvalid !== 1'b0 || data_bif_rvalid !== 1'b0 || bif_err !== 1'b0) begin
      bad++;
      $display("FAIL err_no_rvalid: got irv=%b drv=%b err=%b want 0 0 0", inst_bif_rvalid, data_bif_rvalid, bif_err);
    end
    tick();
    mem_rvalid = 0;
    repeat (3) tick();
    cyc_wait();
    total++;
    if (bif_err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %b want 1", bif_err);
    end
    tick();
    // reset while fetch owns a pending request
    inst_bif_req = 1; inst_bif_addr = 32'h600;
    cyc_wait();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
      bad++;
      $display("FAIL err_pre_reset_req: got req=%b addr=%h want 1 00000600", mem_req, mem_addr);
    end
    tick();
    #2 rstn = 0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || bif_err !== 1'b0 || inst_bif_ack !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got req=%b addr=%h err=%b want 0 0 0", mem_req, mem_addr, bif_err);
    end
    tick();
    rstn = 1;
    inst_bif_addr = 32'h700; mem_ack = 1;
    cyc_wait();
    total++;
    if (inst_bif_ack !== 1'b1 || mem_addr !== 32'h700 || bif_err !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_idle: got iack=%b addr=%h err=%b want 1 00000700 0", inst_bif_ack, mem_addr, bif_err);
    end
    tick();
    inst_bif_req = 0; mem_ack = 0; mem_rvalid = 1;
    cyc_wait();
    total++;
    if (inst_bif_rvalid !== 1'b1 || bif_err !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_resp: got irv=%b err=%b want 1 0", inst_bif_rvalid, bif_err);
    end
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      mem_ack    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      if (!inst_bif_req && $urandom_range(0, 2) == 0) begin
        inst_bif_req = 1; inst_bif_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_bif_req && $urandom_range(0, 1) == 0) begin
        data_bif_req   = 1;
        data_bif_addr  = $urandom & 32'hFFFF_FFFC;
        data_bif_rnw   = $urandom_range(0, 1) == 1;
        data_bif_wmask = data_bif_rnw ? 4'h0 : 4'($urandom_range(1, 15));
        data_bif_wdata = $urandom;
      end
      cyc_wait();
      total++;
      if ({mem_req, mem_rnw, inst_bif_ack, data_bif_ack, inst_bif_rvalid, data_bif_rvalid, bif_err}
          !== {e_req, e_rnw, e_iack, e_dack, e_irv, e_drv, m_err}) begin
        bad++;
        $display("FAIL rand_ctrl c=%0d: got %b want %b", c,
                 {mem_req, mem_rnw, inst_bif_ack, data_bif_ack, inst_bif_rvalid, data_bif_rvalid, bif_err},
                 {e_req, e_rnw, e_iack, e_dack, e_irv, e_drv, m_err});
      end
      total++;
      if (mem_addr !== e_addr || mem_wdata !== e_wdata || mem_wmask !== e_wmask ||
          inst_bif_rdata !== e_rdata || data_bif_rdata !== e_rdata) begin
        bad++;
        $display("FAIL rand_data c=%0d: got addr=%h wdata=%h wmask=%h want %h %h %h", c,
                 mem_addr, mem_wdata, mem_wmask, e_addr, e_wdata, e_wmask);
      end
      tick();
      if (e_iack) inst_bif_req = 0;
      if (e_dack) data_bif_req = 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_starvation();
    test_lock();
    test_full();
    test_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_riscv_bif_arb
`default_nettype wire
